// File: rtl/pong_pkg.sv
// pong_pkg: definitions shared by the PONG match sequencer and the end-screen generator.
//   SCORE_W        width of each player's score bus
//   WIN_SCORE_DEF  default number of points that ends a match
//   state_t        match sequencer state encoding (IDLE=0, SERVE=1, PLAY=2, END=3)
package pong_pkg;

    localparam int unsigned SCORE_W       = 2;
    localparam int unsigned WIN_SCORE_DEF = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StServe = 2'd1,
        StPlay  = 2'd2,
        StEnd   = 2'd3
    } state_t;

endpackage

// File: rtl/edge_sync.sv
// edge_sync: optional 2-flop synchronizer followed by a rising-edge pulse generator.
//   pclk   in  clock
//   rst    in  synchronous active-high reset
//   din    in  level input (asynchronous unless BYPASS_SYNC is set)
//   pulse  out one-cycle pulse per rising edge of din
// With BYPASS_SYNC set, din is already in the pclk domain and is only registered once.
// A level that is already high when reset is released is not reported as an edge: the
// input must be seen low after the pipeline has refilled before any pulse is produced.
module edge_sync #(
    parameter bit BYPASS_SYNC = 1'b0
) (
    input  logic pclk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic       src;
    logic       prev_q;
    logic       armed_q;
    logic [1:0] settle_q;

    if (BYPASS_SYNC) begin : g_bypass
        logic in_q;

        always_ff @(posedge pclk) begin
            if (rst) begin
                in_q <= 1'b0;
            end else begin
                in_q <= din;
            end
        end

        assign src = in_q;
    end else begin : g_sync
        logic meta_q;
        logic sync_q;

        always_ff @(posedge pclk) begin
            if (rst) begin
                meta_q <= 1'b0;
                sync_q <= 1'b0;
            end else begin
                meta_q <= din;
                sync_q <= meta_q;
            end
        end

        assign src = sync_q;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            prev_q   <= 1'b0;
            settle_q <= 2'b00;
            armed_q  <= 1'b0;
        end else begin
            prev_q   <= src;
            // settle_q[1] marks that src now carries real input rather than reset zeros
            settle_q <= {settle_q[0], 1'b1};
            if (settle_q[1] && !src) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign pulse = src & ~prev_q & armed_q;

endmodule

// File: rtl/match_ctl.sv
// match_ctl: PONG match sequencer. Owns both scores, sequences serve/play/end-of-match
// and counts frames from vsync.
//   pclk       in   pixel clock
//   rst        in   synchronous active-high reset
//   vsync_in   in   vsync (pclk domain); each rising edge is one frame tick
//   btn_start  in   asynchronous start button
//   goal_p1    in   one-cycle pulse, player 1 scored
//   goal_p2    in   one-cycle pulse, player 2 scored
//   score_p1   out  player 1 score
//   score_p2   out  player 2 score
//   ball_rst   out  holds the ball at centre
//   game_run   out  enables ball and paddle motion
//   match_end  out  high for the whole end-screen period
//   state_dbg  out  current state encoding
module match_ctl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = WIN_SCORE_DEF,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned END_FRAMES   = 300,
    parameter int unsigned FCNT_W       = 9
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               vsync_in,
    input  logic               btn_start,
    input  logic               goal_p1,
    input  logic               goal_p2,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic               ball_rst,
    output logic               game_run,
    output logic               match_end,
    output logic [1:0]         state_dbg
);

    localparam logic [SCORE_W-1:0] WinScore  = SCORE_W'(WIN_SCORE);
    localparam logic [FCNT_W-1:0]  ServeLast = FCNT_W'(SERVE_FRAMES - 1);
    localparam logic [FCNT_W-1:0]  EndLast   = FCNT_W'(END_FRAMES - 1);

    state_t              state_q;
    logic [FCNT_W-1:0]   fcnt_q;
    logic                start_p;
    logic                frame_p;
    logic [SCORE_W-1:0]  p1_inc;
    logic [SCORE_W-1:0]  p2_inc;

    edge_sync #(
        .BYPASS_SYNC(1'b0)
    ) u_btn_sync (
        .pclk (pclk),
        .rst  (rst),
        .din  (btn_start),
        .pulse(start_p)
    );

    edge_sync #(
        .BYPASS_SYNC(1'b1)
    ) u_vsync_edge (
        .pclk (pclk),
        .rst  (rst),
        .din  (vsync_in),
        .pulse(frame_p)
    );

    assign p1_inc    = score_p1 + SCORE_W'(1);
    assign p2_inc    = score_p2 + SCORE_W'(1);
    assign state_dbg = state_q;

    // Decoded outputs are written alongside every state change so they stay registered.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q   <= StIdle;
            fcnt_q    <= '0;
            score_p1  <= '0;
            score_p2  <= '0;
            ball_rst  <= 1'b1;
            game_run  <= 1'b0;
            match_end <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_p) begin
                        state_q <= StServe;
                        fcnt_q  <= '0;
                    end
                end
                StServe: begin
                    if (frame_p) begin
                        if (fcnt_q == ServeLast) begin
                            state_q  <= StPlay;
                            fcnt_q   <= '0;
                            ball_rst <= 1'b0;
                            game_run <= 1'b1;
                        end else begin
                            fcnt_q <= fcnt_q + FCNT_W'(1);
                        end
                    end
                end
                StPlay: begin
                    if (goal_p1 || goal_p2) begin
                        // Simultaneous goals cancel out; only a re-serve happens.
                        logic win;
                        win = 1'b0;
                        if (goal_p1 && !goal_p2) begin
                            score_p1 <= p1_inc;
                            win      = (p1_inc == WinScore);
                        end else if (goal_p2 && !goal_p1) begin
                            score_p2 <= p2_inc;
                            win      = (p2_inc == WinScore);
                        end
                        fcnt_q   <= '0;
                        ball_rst <= 1'b1;
                        game_run <= 1'b0;
                        if (win) begin
                            state_q   <= StEnd;
                            match_end <= 1'b1;
                        end else begin
                            state_q <= StServe;
                        end
                    end
                end
                StEnd: begin
                    if (frame_p) begin
                        if (fcnt_q == EndLast) begin
                            state_q   <= StIdle;
                            fcnt_q    <= '0;
                            score_p1  <= '0;
                            score_p2  <= '0;
                            match_end <= 1'b0;
                        end else begin
                            fcnt_q <= fcnt_q + FCNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_ctl.sv
`timescale 1ns/1ps
module tb_match_ctl;

    localparam int SERVE_FRAMES = 60;
    localparam int END_FRAMES   = 300;
    localparam int WIN          = 3;
    localparam int IDLE = 0, SERVE = 1, PLAY = 2, ENDS = 3;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       vsync_in = 1'b0;
    logic       btn_start = 1'b0;
    logic       goal_p1 = 1'b0;
    logic       goal_p2 = 1'b0;
    logic [1:0] score_p1;
    logic [1:0] score_p2;
    logic       ball_rst;
    logic       game_run;
    logic       match_end;
    logic [1:0] state_dbg;

    match_ctl dut (
        .pclk     (pclk),
        .rst      (rst),
        .vsync_in (vsync_in),
        .btn_start(btn_start),
        .goal_p1  (goal_p1),
        .goal_p2  (goal_p2),
        .score_p1 (score_p1),
        .score_p2 (score_p2),
        .ball_rst (ball_rst),
        .game_run (game_run),
        .match_end(match_end),
        .state_dbg(state_dbg)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [1:0] st;
        logic [1:0] s1;
        logic [1:0] s2;
        logic       br;
        logic       gr;
        logic       me;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    // Reference model: match state, scores and frames elapsed in the current state.
    int m_st = IDLE;
    int m_s1 = 0;
    int m_s2 = 0;
    int m_cnt = 0;

    // Observable outputs follow from the state alone.
    function automatic obs_t mk(int st, int s1, int s2);
        obs_t o;
        o.st = 2'(st);
        o.s1 = 2'(s1);
        o.s2 = 2'(s2);
        o.br = (st != PLAY);
        o.gr = (st == PLAY);
        o.me = (st == ENDS);
        return o;
    endfunction

    task automatic push_model();
        exp_q.push_back(mk(m_st, m_s1, m_s2));
    endtask

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every change of the observable outputs must match the next expected entry.
    obs_t last;
    bit   have_last = 1'b0;
    always @(negedge pclk) begin
        if (mon_en) begin
            obs_t cur;
            cur = {state_dbg, score_p1, score_p2, ball_rst, game_run, match_end};
            if (!have_last || cur !== last) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change actual st=%0d s1=%0d s2=%0d br=%0b gr=%0b me=%0b required no change",
                             cur.st, cur.s1, cur.s2, cur.br, cur.gr, cur.me);
                end else begin
                    obs_t e;
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        failures++;
                        $display("FAIL outputs actual st=%0d s1=%0d s2=%0d br=%0b gr=%0b me=%0b required st=%0d s1=%0d s2=%0d br=%0b gr=%0b me=%0b",
                                 cur.st, cur.s1, cur.s2, cur.br, cur.gr, cur.me,
                                 e.st, e.s1, e.s2, e.br, e.gr, e.me);
                    end
                end
                last      = cur;
                have_last = 1'b1;
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic frame();
        if (m_st == SERVE || m_st == ENDS) begin
            m_cnt++;
            if (m_st == SERVE && m_cnt == SERVE_FRAMES) begin
                m_st  = PLAY;
                m_cnt = 0;
                push_model();
            end else if (m_st == ENDS && m_cnt == END_FRAMES) begin
                m_st  = IDLE;
                m_s1  = 0;
                m_s2  = 0;
                m_cnt = 0;
                push_model();
            end
        end
        vsync_in = 1'b1;
        tick(2);
        vsync_in = 1'b0;
        tick($urandom_range(2, 4));
    endtask

    task automatic serve();
        while (m_st == SERVE) frame();
    endtask

    task automatic press_start();
        bit starts;
        int lat;
        starts = (m_st == IDLE);
        if (starts) begin
            m_st  = SERVE;
            m_cnt = 0;
            push_model();
        end
        btn_start = 1'b1;
        if (starts) begin
            lat = 0;
            for (int i = 1; i <= 8; i++) begin
                tick(1);
                if (state_dbg == 2'd1) begin
                    lat = i;
                    break;
                end
            end
            check("start_latency", lat, 3);
            tick(3);
        end else begin
            tick(6);
        end
        btn_start = 1'b0;
        tick(4);
    endtask

    task automatic goal(bit g1, bit g2);
        bit in_play;
        in_play = (m_st == PLAY);
        if (in_play) begin
            if (g1 && !g2) m_s1++;
            if (g2 && !g1) m_s2++;
            m_st  = (m_s1 == WIN || m_s2 == WIN) ? ENDS : SERVE;
            m_cnt = 0;
            push_model();
        end
        goal_p1 = g1;
        goal_p2 = g2;
        tick(1);
        goal_p1 = 1'b0;
        goal_p2 = 1'b0;
        if (in_play) begin
            check("goal_next_state", int'(state_dbg), m_st);
            check("goal_run_drop", int'(game_run), 0);
        end
        tick(2);
    endtask

    task automatic do_reset();
        if (m_st != IDLE || m_s1 != 0 || m_s2 != 0) begin
            m_st = IDLE;
            m_s1 = 0;
            m_s2 = 0;
            push_model();
        end
        m_cnt = 0;
        rst = 1'b1;
        tick(1);
        check("reset_state", int'(state_dbg), IDLE);
        check("reset_match_end", int'(match_end), 0);
        check("reset_scores", int'({score_p1, score_p2}), 0);
        check("reset_ball_rst", int'(ball_rst), 1);
        rst = 1'b0;
        tick(5);
    endtask

    task automatic summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        #800000;
        failures++;
        $display("FAIL timeout actual=running required=finished");
        summary();
        $finish;
    end

    initial begin
        // Power-on reset: first observation must be the reset values.
        push_model();
        @(posedge pclk);
        #1;
        mon_en = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(5);

        // Full match won by player 1, with ignored inputs sprinkled in.
        press_start();
        goal(1'b1, 1'b0);           // SERVE: ignored
        serve();
        press_start();              // PLAY: ignored
        for (int i = 0; i < WIN; i++) begin
            goal(1'b1, 1'b0);
            if (i < WIN - 1) serve();
        end
        check("end_score_p1", int'(score_p1), 3);
        goal(1'b0, 1'b1);           // END: ignored
        goal(1'b1, 1'b0);
        while (m_st == ENDS) frame();
        check("idle_after_end", int'(state_dbg), IDLE);

        // Simultaneous goals at 1/1, then player 2 wins; reset 10 frames into END.
        press_start();
        serve();
        goal(1'b1, 1'b0);
        serve();
        goal(1'b0, 1'b1);
        serve();
        goal(1'b1, 1'b1);
        check("tie_scores", int'({score_p1, score_p2}), 4'b0101);
        serve();
        goal(1'b1, 1'b0);
        serve();
        goal(1'b0, 1'b1);
        serve();
        goal(1'b0, 1'b1);
        check("lose_score_p2", int'(score_p2), 3);
        repeat (10) frame();
        do_reset();

        // Button held through reset release must not start a match.
        btn_start = 1'b1;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(20);
        check("held_btn_idle", int'(state_dbg), IDLE);
        btn_start = 1'b0;
        tick(6);
        press_start();

        // Randomized matches.
        for (int mtch = 0; mtch < 4; mtch++) begin
            int rally;
            rally = 0;
            if (m_st == IDLE) press_start();
            while (m_st != ENDS) begin
                if (m_st == SERVE) begin
                    if ($urandom_range(0, 3) == 0) goal(1'($urandom), 1'($urandom));
                    serve();
                end else begin
                    int r;
                    if ($urandom_range(0, 4) == 0) press_start();
                    r = (rally < 6) ? $urandom_range(0, 4) : $urandom_range(0, 3);
                    rally++;
                    if (r == 4) goal(1'b1, 1'b1);
                    else if (r < 2) goal(1'b1, 1'b0);
                    else goal(1'b0, 1'b1);
                end
            end
            if ($urandom_range(0, 1) == 0) goal(1'b1, 1'b0);
            if ($urandom_range(0, 1) == 0) begin
                while (m_st == ENDS) frame();
            end else begin
                repeat ($urandom_range(1, 50)) frame();
                do_reset();
            end
        end

        tick(5);
        check("pending_expectations", exp_q.size(), 0);
        summary();
        $finish;
    end

endmodule
